fsm_host: RTL and testbench
===========================

FSM_HOST -- requirements
Module: fsm_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 4096: idle cycles in COLLECT without a result before the run ends.
REQ-002 SHALL have parameter MAX_RES, default 255: maximum results captured per run.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  begins a run; sampled in IDLE only.
REQ-006 SHALL have ports a_in, b_in  in  32 each  IEEE-754 single operands, sampled when start is accepted.
REQ-007 SHALL have ports data_out  out  16 and r_i  out  1  word bus and strobe toward the compute FSM.
REQ-008 SHALL have ports r_o  in  1, err  in  2 and data_in  in  32  result strobe, error code and result from the compute FSM.
REQ-009 SHALL have ports res_valid  out  1, res_data  out  32, res_err  out  2 and res_ready  in  1  result stream.
REQ-010 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), done_err  out  2, res_cnt  out  8 and ovf  out  1 (sticky).

Function
REQ-011 SHALL implement the states IDLE, SEND_AH, SEND_AL, SEND_BH, SEND_BL, COLLECT and DONE.
REQ-012 SHALL move IDLE->SEND_AH when start=1, latching a_in and b_in, clearing res_cnt, done_err and the timeout counter.
REQ-013 SHALL drive, on 4 consecutive cycles with r_i=1: a[31:16], a[15:0], b[31:16], b[15:0]; r_i=0 and data_out=0 in every other state.
REQ-014 SHALL treat a result as present only on an r_o rising edge (r_o=1 now, 0 on the previous cycle) while in COLLECT; r_o held high SHALL NOT produce a second capture.
REQ-015 SHALL, on capture, emit data_in and err as a result, increment res_cnt, and reset the timeout counter.
REQ-016 SHALL go to DONE with done_err=err when a capture has err!=0 (2'b11 zero a, 2'b10 fractional b, 2'b01 pow overflow).
REQ-017 SHALL go to DONE with done_err=0 after TIMEOUT_CYC consecutive COLLECT cycles with no capture, or when res_cnt reaches MAX_RES.
REQ-018 SHALL give a capture priority over a timeout expiring in the same cycle.
REQ-019 SHALL pulse done for one cycle in DONE, then return to IDLE; busy=1 in every state except IDLE.
REQ-020 SHALL ignore start while busy=1.

Reset
REQ-021 SHALL, when reset=1 at any time including mid-send, immediately force IDLE, r_i=0, data_out=0, res_valid=0, done=0, busy=0, done_err=0, res_cnt=0, ovf=0, clear the r_o edge history, and empty the FIFO if present.

Configuration
REQ-022 SHALL, with FSM_HOST_RESULT_FIFO_EN defined, buffer results in a 4-entry FIFO: res_valid=not-empty, pop on res_valid&res_ready, capture into a full FIFO dropped and ovf set.
REQ-023 SHALL, without FSM_HOST_RESULT_FIFO_EN, present each result as a one-cycle res_valid pulse the cycle after capture, ignore res_ready, and hold ovf=0.

Structure
REQ-024 SHALL place the state enum, the word-index constants and the err code constants in package fsm_host_pkg.
REQ-025 SHALL implement the FIFO as sub-module fsm_host_fifo, instantiated only under FSM_HOST_RESULT_FIFO_EN.

Verification
REQ-026 SHALL cover: start, a=0x40000000, b=0x40400000 -> data_out 0x4000, 0x0000, 0x4040, 0x0000 with r_i=1 on 4 consecutive cycles.
REQ-027 SHALL cover: r_o high for 3 cycles with data_in=0x40800000 and err=0 -> exactly one result 0x40800000, res_cnt=1.
REQ-028 SHALL cover: capture with err=2'b11 -> res_err=3, then done pulse with done_err=3, then IDLE.
REQ-029 SHALL cover: no r_o edge for TIMEOUT_CYC=16 cycles -> done on the 16th cycle, done_err=0.
REQ-030 SHALL cover: reset asserted during SEND_AL -> r_i=0 and busy=0 immediately, with no further words sent.
REQ-031 SHALL cover, with FSM_HOST_RESULT_FIFO_EN defined: res_ready=0 and 5 captures -> 4 results held and ovf=1.

Source files
------------

// File: rtl/fsm_host_pkg.sv
// Shared types and constants for the fsm_host operand sender / result collector.
// Optional result FIFO is enabled with the FSM_HOST_RESULT_FIFO_EN macro.
package fsm_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_AH = 3'd1,
    ST_SEND_AL = 3'd2,
    ST_SEND_BH = 3'd3,
    ST_SEND_BL = 3'd4,
    ST_COLLECT = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Order in which the 16-bit operand halves are sent to the compute FSM.
  localparam logic [1:0] WORD_AH = 2'd0;
  localparam logic [1:0] WORD_AL = 2'd1;
  localparam logic [1:0] WORD_BH = 2'd2;
  localparam logic [1:0] WORD_BL = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_POW_OVF = 2'b01;
  localparam logic [1:0] ERR_FRAC_B  = 2'b10;
  localparam logic [1:0] ERR_ZERO_A  = 2'b11;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned RES_W      = 34;

  function automatic logic [15:0] word_sel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] idx);
    case (idx)
      WORD_AH: return a[31:16];
      WORD_AL: return a[15:0];
      WORD_BH: return b[31:16];
      default: return b[15:0];
    endcase
  endfunction

endpackage

// File: rtl/fsm_host_if.sv
// Bus between fsm_host, the compute FSM and the result consumer.
// res_valid/res_ready: a result transfers on a cycle where both are 1; in the
// FIFO build res_valid holds with stable data until taken, otherwise it is a
// one-cycle pulse and res_ready is not consulted.
interface fsm_host_if;
  logic [15:0] data_out;
  logic        r_i;
  logic        r_o;
  logic [1:0]  err;
  logic [31:0] data_in;
  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_err;
  logic        res_ready;

  modport master (
    output data_out, r_i,
    input  r_o, err, data_in,
    output res_valid, res_data, res_err,
    input  res_ready
  );

  modport slave (
    input  data_out, r_i,
    output r_o, err, data_in,
    input  res_valid, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/fsm_host_fifo.sv
// Small synchronous FIFO for captured results; pushes into a full FIFO are dropped.
module fsm_host_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fsm_host.sv
// Sends two float operands as four 16-bit words to a compute FSM, then collects
// its results until an error, MAX_RES results or a timeout. Macro: FSM_HOST_RESULT_FIFO_EN.
module fsm_host
  import fsm_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned MAX_RES     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  fsm_host_if.master  bus,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_err,
  output logic [7:0]  res_cnt,
  output logic        ovf,
  output state_t      dbg_state
);
  localparam int unsigned   TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_RES_C = 8'(MAX_RES);

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          r_o_q;
  logic [TW-1:0] tmo_q;
  logic          capture;
  logic          tmo_hit;
  logic          r_i_c;
  logic [15:0]   data_out_c;

  // A result counts only on a rising edge of r_o seen while collecting.
  assign capture = (state == ST_COLLECT) && bus.r_o && !r_o_q;
  assign tmo_hit = (state == ST_COLLECT) && !capture && (tmo_q == TMO_LAST);

  assign bus.r_i      = r_i_c;
  assign bus.data_out = data_out_c;
  assign dbg_state    = state;

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    r_i_c      = 1'b0;
    data_out_c = 16'h0000;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_SEND_AH;
      end
      ST_SEND_AH: begin
        r_i_c      = 1'b1;
        data_out_c = word_sel(a_q, b_q, WORD_AH);
        state_nxt  = ST_SEND_AL;
      end
      ST_SEND_AL: begin
        r_i_c      = 1'b1;
        data_out_c = word_sel(a_q, b_q, WORD_AL);
        state_nxt  = ST_SEND_BH;
      end
      ST_SEND_BH: begin
        r_i_c      = 1'b1;
        data_out_c = word_sel(a_q, b_q, WORD_BH);
        state_nxt  = ST_SEND_BL;
      end
      ST_SEND_BL: begin
        r_i_c      = 1'b1;
        data_out_c = word_sel(a_q, b_q, WORD_BL);
        state_nxt  = ST_COLLECT;
      end
      ST_COLLECT: begin
        // Capture wins over a timeout expiring on the same cycle.
        if (capture) begin
          if ((bus.err != ERR_NONE) || ((res_cnt + 8'd1) == MAX_RES_C)) state_nxt = ST_DONE;
        end else if (tmo_hit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_o_q    <= 1'b0;
      tmo_q    <= '0;
      res_cnt  <= '0;
      done_err <= ERR_NONE;
    end else begin
      state <= state_nxt;
      r_o_q <= bus.r_o;
      if ((state == ST_IDLE) && start) begin
        a_q      <= a_in;
        b_q      <= b_in;
        res_cnt  <= '0;
        done_err <= ERR_NONE;
        tmo_q    <= '0;
      end
      if (capture) begin
        res_cnt <= res_cnt + 8'd1;
        tmo_q   <= '0;
        if (bus.err != ERR_NONE) done_err <= bus.err;
      end else if (state == ST_COLLECT) begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

`ifdef FSM_HOST_RESULT_FIFO_EN
  logic [RES_W-1:0] fifo_out;
  logic             fifo_empty;
  logic             fifo_full;
  logic             ovf_q;

  fsm_host_fifo #(
    .WIDTH(RES_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (capture),
    .push_data({bus.err, bus.data_in}),
    .pop      (bus.res_valid && bus.res_ready),
    .pop_data (fifo_out),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else if (capture && fifo_full) ovf_q <= 1'b1;
  end

  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = fifo_out[31:0];
  assign bus.res_err   = fifo_out[33:32];
  assign ovf           = ovf_q;
`else
  logic        res_valid_q;
  logic [31:0] res_data_q;
  logic [1:0]  res_err_q;
  logic        unused_res_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= ERR_NONE;
    end else begin
      res_valid_q <= capture;
      if (capture) begin
        res_data_q <= bus.data_in;
        res_err_q  <= bus.err;
      end
    end
  end

  assign unused_res_ready = bus.res_ready;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_err      = res_err_q;
  assign ovf              = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_host.sv
// Randomized bench for fsm_host against a transaction-level model of runs and results.
module tb_fsm_host;
  import fsm_host_pkg::*;

  localparam int TMO  = 16;
  localparam int MAXR = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [1:0]  done_err;
  logic [7:0]  res_cnt;
  logic        ovf;
  state_t      dbg_state;

  fsm_host_if bus();

  fsm_host #(.TIMEOUT_CYC(TMO), .MAX_RES(MAXR)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .done_err (done_err),
    .res_cnt  (res_cnt),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [33:0] exp_q[$];
  int          exp_cnt  = 0;
  bit          exp_ovf  = 0;
  int          ref_cyc  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_result();
    logic [33:0] e;
    check("res_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("res_data", bus.res_data, e[31:0]);
      check("res_err", bus.res_err, e[33:32]);
    end
  endtask

  // result monitor
  always @(negedge clk) begin
    if (!reset && bus.res_valid) begin
`ifdef FSM_HOST_RESULT_FIFO_EN
      if (bus.res_ready) pop_result();
`else
      pop_result();
`endif
    end
  end

  // drivers
  task automatic start_run(input logic [31:0] a, input logic [31:0] b, input int nw);
    logic [15:0] w[4];
    w[0] = a[31:16];
    w[1] = a[15:0];
    w[2] = b[31:16];
    w[3] = b[15:0];
    @(negedge clk);
    check("idle_busy", busy, 0);
    start   = 1'b1;
    a_in    = a;
    b_in    = b;
    exp_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    for (int i = 0; i < nw; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("word%0d_r_i", i), bus.r_i, 1);
      check($sformatf("word%0d_data", i), bus.data_out, w[i]);
      check($sformatf("word%0d_busy", i), busy, 1);
    end
    ref_cyc = cyc;
  endtask

  task automatic rise(input int gap, input int hold, input logic [31:0] d, input logic [1:0] e);
    repeat (gap) begin
      @(negedge clk);
      check("collect_r_i", bus.r_i, 0);
      check("collect_data_out", bus.data_out, 0);
      check("collect_busy", busy, 1);
      start = 1'($urandom_range(0, 1));
      a_in  = $urandom;
    end
    start       = 1'b0;
    bus.r_o     = 1'b1;
    bus.data_in = d;
    bus.err     = e;
    exp_cnt++;
    ref_cyc = cyc;
`ifdef FSM_HOST_RESULT_FIFO_EN
    if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1;
    else exp_q.push_back({e, d});
`else
    exp_q.push_back({e, d});
`endif
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      bus.data_in = $urandom;
      bus.err     = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    bus.r_o     = 1'b0;
    bus.err     = 2'b00;
    bus.data_in = $urandom;
    check("res_cnt", res_cnt, exp_cnt);
  endtask

  task automatic wait_done(input logic [1:0] e, input int lat);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_latency", cyc - ref_cyc, lat);
      check("done_err", done_err, e);
      check("done_res_cnt", res_cnt, exp_cnt);
      check("done_busy", busy, 1);
    end
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("after_done_busy", busy, 0);
    check("after_done_err", done_err, e);
    check("ovf", ovf, exp_ovf);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input int n,
                     input logic [1:0] last_err);
    bit          term = 0;
    logic [1:0]  e    = 2'b00;
    start_run(a, b, 4);
    for (int i = 0; i < n && !term; i++) begin
      e    = (i == n - 1) ? last_err : 2'b00;
      term = (e != 2'b00) || (exp_cnt + 1 == MAXR);
      rise($urandom_range(1, 6), term ? 1 : $urandom_range(1, 4), $urandom, e);
    end
    wait_done(term ? e : 2'b00, term ? 1 : TMO + 1);
    check("res_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    a_in        = '0;
    b_in        = '0;
    bus.r_o     = 1'b0;
    bus.err     = 2'b00;
    bus.data_in = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_r_i", bus.r_i, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_done_err", done_err, 0);
    reset = 1'b0;
    @(posedge clk);
    #1 bus.res_ready = 1'b1;

    // known operands, no results -> timeout
    run(32'h4000_0000, 32'h4040_0000, 0, 2'b00);

    // held r_o gives one result; capture lands on the last timeout cycle
    start_run($urandom, $urandom, 4);
    rise(TMO, 3, 32'h4080_0000, 2'b00);
    wait_done(2'b00, TMO + 1);
    check("held_drained", exp_q.size(), 0);

    // first result carries zero-a error
    run($urandom, $urandom, 1, ERR_ZERO_A);

    // result count limit
    run($urandom, $urandom, MAXR, 2'b00);

    for (int r = 0; r < 10; r++) begin
`ifndef FSM_HOST_RESULT_FIFO_EN
      bus.res_ready = 1'($urandom_range(0, 1));
`endif
      run($urandom, $urandom, $urandom_range(0, 4),
          ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    // consumer stalled: five results
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    start_run($urandom, $urandom, 4);
    for (int i = 0; i < 5; i++) rise($urandom_range(1, 4), $urandom_range(1, 3), $urandom, 2'b00);
    wait_done(2'b00, TMO + 1);
`ifdef FSM_HOST_RESULT_FIFO_EN
    check("fifo_held_valid", bus.res_valid, 1);
    check("fifo_held_count", exp_q.size(), FIFO_DEPTH);
`endif
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("stall_drained", exp_q.size(), 0);
    check("stall_valid_low", bus.res_valid, 0);

    // reset during the second word
    start_run(32'h1234_5678, 32'h9abc_def0, 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_r_i", bus.r_i, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data_out", bus.data_out, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_res_cnt", res_cnt, 0);
    exp_q.delete();
    exp_ovf = 0;
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("postrst_r_i", bus.r_i, 0);
      check("postrst_busy", busy, 0);
    end

    run($urandom, $urandom, 2, ERR_FRAC_B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
